qcldpc_bitflip_decoder: RTL
===========================

Name: qcldpc_bitflip_decoder

Overview:
- Receive-side counterpart of the QC-LDPC encoder: accepts one received hard-decision codeword, one Z-bit circulant block per beat, columns 0..TOTAL_BLKS-1, info blocks first and parity blocks after.
- Computes the syndrome against the protomatrix and, if it is nonzero, runs iterative column-serial bit-flipping decoding.
- Streams the corrected info blocks out with a pass/fail status.
- Rotation convention matches the encoder: rotl(x,s) = (x<<s)|(x>>(Z-s)).

Parameters:
- Z, 27: circulant size (block width in bits).
- NUM_INFO_BLKS, 20: info blocks per codeword.
- NUM_PARITY_BLKS, 4: parity blocks, which is also the number of protomatrix rows.
- TOTAL_BLKS, NUM_INFO_BLKS+NUM_PARITY_BLKS: derived block count.
- PROTO[NUM_PARITY_BLKS][TOTAL_BLKS], all -1: shift per (row,col). Value -1 means a zero block; valid values are 0..Z-1. The default must be overridden by the instantiating design.
- MAX_ITER, 8: bit-flip iteration cap. Value 0 means syndrome check only.

Ports:
- CLK  in  1  clock
- rst  in  1  reset, synchronous to CLK, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  decoder accepts an input block
- in_blk  in  Z  received block, bit i = circulant position i
- out_valid  out  1  output block valid
- out_ready  in  1  sink accepts an output block
- out_blk  out  Z  corrected info block
- out_last  out  1  marks info block NUM_INFO_BLKS-1
- out_ok  out  1  final syndrome zero; valid while out_valid=1
- out_iters  out  $clog2(MAX_ITER+1)  iterations used; valid while out_valid=1

Behaviour:
- Reset (rst=1 at a CLK edge):
  - state=LOAD; column counter, iteration counter and syndrome regs S[0..NUM_PARITY_BLKS-1] cleared.
  - in_ready=1, out_valid=0, out_last=0, out_ok=0, out_iters=0, out_blk=0.
  - Reset mid-frame in any state discards the frame; no partial output is produced.
- Handshake: a transfer occurs when valid & ready are both 1 at a CLK edge. out_blk, out_last, out_ok and out_iters hold stable while out_valid=1 & out_ready=0.
- LOAD (in_ready=1):
  - Each accepted block c is written to buffer[c].
  - For every row r with PROTO[r][c]≠-1: S[r] ^= rotl(in_blk, PROTO[r][c]).
  - After accepting block TOTAL_BLKS-1, move to CHECK. in_ready=0 in every state except LOAD.
- CHECK (1 cycle):
  - All S=0: go to OUT with ok=1.
  - Otherwise, if iter==MAX_ITER: go to OUT with ok=0; the buffer holds the best-effort data.
  - Otherwise: go to DECODE with col=0.
- DECODE, one column c per cycle:
  - deg(c) = number of rows r with PROTO[r][c]≠-1. Per bit i, cnt[i] = sum over those rows of bit i of rotr(S[r], PROTO[r][c]).
  - flip[i] = (2*cnt[i] > deg(c)). Columns with deg 0 never flip.
  - Same edge: buffer[c] ^= flip; S[r] ^= rotl(flip, PROTO[r][c]) for every row r with a nonzero entry.
  - Column c+1 sees the updated syndrome. At c=TOTAL_BLKS-1, iter++ and return to CHECK.
- OUT:
  - Present buffer[0..NUM_INFO_BLKS-1] in order; out_last=1 on the final block.
  - The transfer with out_last=1 clears S, the counters and iter, and returns to LOAD (in_ready=1 next cycle).
  - Parity blocks are never output.
- Latency:
  - Error-free: out_valid rises 2 cycles after the last input transfer (one CHECK cycle, then OUT).
  - Each iteration adds TOTAL_BLKS+1 cycles.
- Widths:
  - cnt is $clog2(NUM_PARITY_BLKS+1) bits.
  - The shift operand is $clog2(Z) bits.
  - Shift 0 is identity; no Z-shift wrap is produced (rotl by 0 must return x, not x|x>>Z artefacts).
- Input is accepted only in LOAD. The bench must not assume buffering across frames: one frame in flight.

Test Plan:
Config for all tests: Z=4, NUM_INFO_BLKS=2, NUM_PARITY_BLKS=2, PROTO={{0,1,0,-1},{2,-1,0,0}}, MAX_ITER=8, unless stated otherwise.
- Valid codeword 0001,0000,0001,0101 -> out 0001 then 0000 (out_last=1 on second), out_ok=1, out_iters=0, out_valid 2 cycles after last input.
- All-zero codeword with blk0=0001 (single error, col0 bit0) -> corrected in DECODE col0; out 0000,0000; out_ok=1; out_iters=1.
- Valid codeword with blk3=0100 (error in degree-1 col3 bit0) -> out 0001,0000; out_ok=1; out_iters=1.
- MAX_ITER=0, input 0001,0000,0000,0000 -> no decode; out 0001,0000; out_ok=0; out_iters=0.
- Backpressure: out_ready=0 for 5 cycles during OUT -> out_blk, out_last and status held stable; in_ready stays 0; after release the frame completes and in_ready=1 the cycle after the out_last transfer.
- Reset: assert rst after 2 input blocks, then send the valid codeword -> only that codeword's outputs appear, out_ok=1, out_iters=0; all outputs are 0 during and after the reset cycle.

Source files
------------

// File: rtl/qcldpc_bitflip_decoder.sv
// QC-LDPC hard-decision receiver: loads one codeword, checks the syndrome and,
// if needed, runs column-serial bit-flipping before streaming the info blocks.
module qcldpc_bitflip_decoder #(
  parameter int Z               = 27,
  parameter int NUM_INFO_BLKS   = 20,
  parameter int NUM_PARITY_BLKS = 4,
  localparam int TOTAL_BLKS     = NUM_INFO_BLKS + NUM_PARITY_BLKS,
  parameter int PROTO [NUM_PARITY_BLKS][TOTAL_BLKS] = '{default: '{default: -1}},
  parameter int MAX_ITER        = 8,
  localparam int ITW            = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z-1:0]   in_blk,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Z-1:0]   out_blk,
  output logic           out_last,
  output logic           out_ok,
  output logic [ITW-1:0] out_iters
);

  localparam int SW  = (Z > 1) ? $clog2(Z) : 1;
  localparam int CNW = $clog2(NUM_PARITY_BLKS + 1);
  localparam int CW  = (TOTAL_BLKS > 1) ? $clog2(TOTAL_BLKS) : 1;

  // states: LOAD accept blocks | CHECK test syndrome | DECODE flip one column | OUT stream info
  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_col;
  logic [ITW-1:0] r_iter;
  logic           r_ok;
  logic [Z-1:0]   r_syn [NUM_PARITY_BLKS];
  logic [Z-1:0]   r_buf [TOTAL_BLKS];

  logic [SW-1:0]  w_sh   [NUM_PARITY_BLKS];
  logic           w_en   [NUM_PARITY_BLKS];
  logic [Z-1:0]   w_rr   [NUM_PARITY_BLKS];
  logic [Z-1:0]   w_upd  [NUM_PARITY_BLKS];
  logic [CNW-1:0] w_cnt  [Z];
  logic [CNW-1:0] w_deg;
  logic [Z-1:0]   w_flip;
  logic [Z-1:0]   w_src;
  logic [Z-1:0]   w_cur;
  logic           w_syn_zero;
  logic           w_last_col;
  logic           w_last_info;

  // Zero shift is handled explicitly so no x>>Z term ever appears.
  function automatic logic [Z-1:0] rotl(input logic [Z-1:0] x, input logic [SW-1:0] s);
    if (s == '0) return x;
    return (x << s) | (x >> (Z - int'(s)));
  endfunction

  function automatic logic [Z-1:0] rotr(input logic [Z-1:0] x, input logic [SW-1:0] s);
    if (s == '0) return x;
    return (x >> s) | (x << (Z - int'(s)));
  endfunction

  always_comb begin
    w_deg = '0;
    for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
      w_sh[r] = '0;
      w_en[r] = 1'b0;
    end
    for (int c = 0; c < TOTAL_BLKS; c++) begin
      if (r_col == CW'(c)) begin
        for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
          if (PROTO[r][c] >= 0) begin
            w_en[r] = 1'b1;
            w_sh[r] = SW'(PROTO[r][c]);
            w_deg   = w_deg + CNW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
      w_rr[r] = rotr(r_syn[r], w_sh[r]);
    end
    for (int i = 0; i < Z; i++) begin
      w_cnt[i] = '0;
      for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
        if (w_en[r]) w_cnt[i] = w_cnt[i] + CNW'(w_rr[r][i]);
      end
      w_flip[i] = {1'b0, w_cnt[i], 1'b0} > {2'b00, w_deg};
    end
  end

  // One shared rotator per row serves both syndrome accumulation and flip feedback.
  always_comb begin
    w_src = (r_state == ST_LOAD) ? in_blk : w_flip;
    w_syn_zero = 1'b1;
    for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
      w_upd[r] = w_en[r] ? rotl(w_src, w_sh[r]) : '0;
      if (r_syn[r] != '0) w_syn_zero = 1'b0;
    end
  end

  assign w_cur       = r_buf[r_col];
  assign w_last_col  = (r_col == CW'(TOTAL_BLKS - 1));
  assign w_last_info = (r_col == CW'(NUM_INFO_BLKS - 1));

  always_ff @(posedge CLK) begin
    if (r_state == ST_LOAD && in_valid) begin
      r_buf[r_col] <= in_blk;
    end else if (r_state == ST_DECODE) begin
      r_buf[r_col] <= w_cur ^ w_flip;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_col   <= '0;
      r_iter  <= '0;
      r_ok    <= 1'b0;
      for (int r = 0; r < NUM_PARITY_BLKS; r++) r_syn[r] <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            for (int r = 0; r < NUM_PARITY_BLKS; r++) r_syn[r] <= r_syn[r] ^ w_upd[r];
            if (w_last_col) begin
              r_state <= ST_CHECK;
              r_col   <= '0;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ST_CHECK: begin
          r_col <= '0;
          if (w_syn_zero) begin
            r_ok    <= 1'b1;
            r_state <= ST_OUT;
          end else if (r_iter == ITW'(MAX_ITER)) begin
            r_ok    <= 1'b0;
            r_state <= ST_OUT;
          end else begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          for (int r = 0; r < NUM_PARITY_BLKS; r++) r_syn[r] <= r_syn[r] ^ w_upd[r];
          if (w_last_col) begin
            r_col   <= '0;
            r_iter  <= r_iter + ITW'(1);
            r_state <= ST_CHECK;
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        default: begin
          if (out_ready) begin
            if (w_last_info) begin
              r_state <= ST_LOAD;
              r_col   <= '0;
              r_iter  <= '0;
              r_ok    <= 1'b0;
              for (int r = 0; r < NUM_PARITY_BLKS; r++) r_syn[r] <= '0;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_OUT);
  assign out_blk   = out_valid ? w_cur : '0;
  assign out_last  = out_valid & w_last_info;
  assign out_ok    = out_valid & r_ok;
  assign out_iters = out_valid ? r_iter : '0;

endmodule
